// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: source/destination decode, writeback bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  output logic        id_stall,
  output logic [3:0]  SrcReg1,
  output logic [3:0]  SrcReg2,
  input  logic [15:0] SrcData1,
  input  logic [15:0] SrcData2,
  input  logic        wb_wen,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_data,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_opcode,
  output logic [3:0]  ex_dst,
  output logic        ex_wen,
  output logic [3:0]  ex_src1,
  output logic [3:0]  ex_src2,
  output logic [15:0] ex_op1,
  output logic [15:0] ex_op2,
  output logic [7:0]  ex_imm8
);

  logic [3:0]  opcode, rd, rs, rt;
  logic        idWen;
  logic [15:0] op1, op2;
  logic        hazard;

  assign opcode = id_instr[15:12];
  assign rd     = id_instr[11:8];
  assign rs     = id_instr[7:4];
  assign rt     = id_instr[3:0];

  // Unused sources decode to register 0, so they never bypass or hazard.
  always_comb begin
    SrcReg1 = 4'h0;
    SrcReg2 = 4'h0;
    idWen   = 1'b0;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        SrcReg1 = rs;
        SrcReg2 = rt;
        idWen   = 1'b1;
      end
      4'h8: begin
        SrcReg1 = rs;
        idWen   = 1'b1;
      end
      4'h9: begin
        SrcReg1 = rs;
        SrcReg2 = rd;
      end
      4'hA, 4'hB: begin
        SrcReg1 = rd;
        idWen   = 1'b1;
      end
      4'hE: idWen = 1'b1;
      default: ;
    endcase
    if (rd == 4'h0) idWen = 1'b0;
  end

  // The file commits on the edge, so same-cycle writeback must be forwarded.
  always_comb begin
    if (SrcReg1 == 4'h0)                         op1 = 16'h0000;
    else if (wb_wen && (wb_reg == SrcReg1))      op1 = wb_data;
    else                                         op1 = SrcData1;
    if (SrcReg2 == 4'h0)                         op2 = 16'h0000;
    else if (wb_wen && (wb_reg == SrcReg2))      op2 = wb_data;
    else                                         op2 = SrcData2;
  end

  always_comb begin
    hazard = 1'b0;
    if (id_valid && ex_valid && (ex_opcode == 4'h8) && ex_wen) begin
      if ((SrcReg1 != 4'h0) && (ex_dst == SrcReg1)) hazard = 1'b1;
      if ((SrcReg2 != 4'h0) && (ex_dst == SrcReg2)) hazard = 1'b1;
    end
    id_stall = hazard && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid  <= 1'b0;
      ex_opcode <= 4'h0;
      ex_dst    <= 4'h0;
      ex_wen    <= 1'b0;
      ex_src1   <= 4'h0;
      ex_src2   <= 4'h0;
      ex_op1    <= 16'h0000;
      ex_op2    <= 16'h0000;
      ex_imm8   <= 8'h00;
    end else if (id_stall) begin
      ex_valid <= 1'b0;
      ex_wen   <= 1'b0;
    end else begin
      ex_valid  <= id_valid;
      ex_opcode <= opcode;
      ex_dst    <= rd;
      ex_wen    <= idWen && id_valid;
      ex_src1   <= SrcReg1;
      ex_src2   <= SrcReg2;
      ex_op1    <= op1;
      ex_op2    <= op2;
      ex_imm8   <= id_instr[7:0];
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized plus directed bench for id_operand_stage against a cycle-level
// reference model of the decode rules, bypass, hazard and ID/EX register.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_stall, wb_wen, flush;
  logic [15:0] id_instr, SrcData1, SrcData2, wb_data;
  logic [3:0]  SrcReg1, SrcReg2, wb_reg;
  logic        ex_valid, ex_wen;
  logic [3:0]  ex_opcode, ex_dst, ex_src1, ex_src2;
  logic [15:0] ex_op1, ex_op2;
  logic [7:0]  ex_imm8;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_stall(id_stall),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .SrcData1(SrcData1), .SrcData2(SrcData2),
    .wb_wen(wb_wen), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dst(ex_dst), .ex_wen(ex_wen),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm8(ex_imm8)
  );

  always #5 clk = ~clk;

  // Register file model; entry 0 holds garbage so the stage must force zero.
  logic [15:0] rf [16];
  assign SrcData1 = rf[SrcReg1];
  assign SrcData2 = rf[SrcReg2];

  int unsigned nVec = 0;
  int unsigned nBad = 0;

  // Model of ID/EX; mFull is 0 when a stall bubble left the payload unspecified.
  logic        mValid, mWen, mFull;
  logic [3:0]  mOpc, mDst, mS1, mS2;
  logic [15:0] mOp1, mOp2;
  logic [7:0]  mImm;
  logic        lastStall;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [15:0] ins,
                       input logic ww, input logic [3:0] wr, input logic [15:0] wd,
                       input logic fl);
    logic [3:0]  opc, rd, rs, rt, s1, s2;
    logic        w, stall;
    logic [15:0] o1, o2;
    rst = r; id_valid = v; id_instr = ins; wb_wen = ww; wb_reg = wr; wb_data = wd; flush = fl;
    #2;
    opc = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    s1 = (opc <= 4'h9) ? rs : ((opc == 4'hA || opc == 4'hB) ? rd : 4'h0);
    s2 = (opc <= 4'h7) ? rt : ((opc == 4'h9) ? rd : 4'h0);
    w  = ((opc <= 4'h8) || opc == 4'hA || opc == 4'hB || opc == 4'hE) && (rd != 4'h0);
    o1 = (s1 == 0) ? 16'h0 : ((ww && wr == s1) ? wd : rf[s1]);
    o2 = (s2 == 0) ? 16'h0 : ((ww && wr == s2) ? wd : rf[s2]);
    stall = v && mValid && mOpc == 4'h8 && mWen && !fl &&
            ((s1 != 0 && s1 == mDst) || (s2 != 0 && s2 == mDst));
    check("SrcReg1", SrcReg1, s1);
    check("SrcReg2", SrcReg2, s2);
    check("id_stall", id_stall, stall);
    if (r || fl) begin
      {mValid, mWen, mOpc, mDst, mS1, mS2, mOp1, mOp2, mImm} = '0;
      mFull = 1'b1;
    end else if (stall) begin
      mValid = 1'b0; mWen = 1'b0; mFull = 1'b0;
    end else begin
      mValid = v; mWen = w && v; mOpc = opc; mDst = rd; mS1 = s1; mS2 = s2;
      mOp1 = o1; mOp2 = o2; mImm = ins[7:0]; mFull = 1'b1;
    end
    lastStall = stall;
    @(posedge clk);
    if (ww && wr != 0) rf[wr] = wd;
    #1;
    check("ex_valid", ex_valid, mValid);
    check("ex_wen", ex_wen, mWen);
    if (mFull) begin
      check("ex_opcode", ex_opcode, mOpc);
      check("ex_dst", ex_dst, mDst);
      check("ex_src1", ex_src1, mS1);
      check("ex_src2", ex_src2, mS2);
      check("ex_op1", ex_op1, mOp1);
      check("ex_op2", ex_op2, mOp2);
      check("ex_imm8", ex_imm8, mImm);
    end
  endtask

  initial begin
    logic [15:0] ins;
    logic        v;
    for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h1111);
    rf[0] = 16'hDEAD;
    {mValid, mWen, mOpc, mDst, mS1, mS2, mOp1, mOp2, mImm} = '0;
    mFull = 1'b1;
    lastStall = 1'b0;

    // Reset with a valid instruction present.
    cycle(1, 1, 16'h0312, 0, 0, 0, 0);
    cycle(1, 1, 16'h0312, 0, 0, 0, 0);

    rf[1] = 16'h0005; rf[2] = 16'h0007;
    cycle(0, 1, 16'h0312, 0, 0, 16'h0, 0);       // ADD R3,R1,R2
    cycle(0, 1, 16'h0312, 1, 0, 16'hBEEF, 0);    // wb to R0: no bypass
    cycle(0, 1, 16'h0312, 1, 2, 16'hBEEF, 0);    // bypass port 2
    cycle(0, 1, 16'h0312, 1, 1, 16'hAAAA, 0);    // bypass port 1

    cycle(0, 1, 16'h8410, 0, 0, 0, 0);           // LW R4,[R1]
    cycle(0, 1, 16'h1541, 0, 0, 0, 0);           // SUB R5,R4,R1 stalls
    cycle(0, 1, 16'h1541, 1, 4, 16'hCAFE, 0);    // load data bypassed

    cycle(0, 1, 16'h8410, 0, 0, 0, 0);
    cycle(0, 1, 16'h1541, 0, 0, 0, 1);           // flush masks stall

    cycle(0, 1, 16'h0000, 1, 0, 16'h1234, 0);    // ADD R0,R0,R0
    cycle(0, 1, 16'h9210, 0, 0, 0, 0);           // SW R2,[R1]
    cycle(0, 1, 16'h1444, 1, 4, 16'h5A5A, 0);    // both ports bypass same reg
    cycle(0, 0, 16'h8410, 0, 0, 0, 0);           // invalid slot

    ins = 16'h0;
    v = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if (!lastStall) begin
        ins[15:12] = ($urandom_range(0, 3) == 0) ? 4'h8 : 4'($urandom_range(0, 15));
        ins[11:8]  = 4'($urandom_range(0, 5));
        ins[7:4]   = 4'($urandom_range(0, 5));
        ins[3:0]   = 4'($urandom_range(0, 5));
        v = ($urandom_range(0, 3) != 0);
      end
      cycle(($urandom_range(0, 39) == 0), v, ins, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 6)), 16'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Decode/operand-fetch stage of the 16-bit pipelined core, sitting directly upstream of the register file. It takes the instruction held in IF/ID and decides which registers it reads and writes. It drives the register file read addresses, bypasses same-cycle writeback data around the file, and detects load-use hazards. It then loads the ID/EX pipeline register consumed by the execute stage.

## Interface
- Parameters: none. Data width is fixed at 16 bits and the register index at 4 bits.
- clk  in  1  core clock. All state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_instr  in  16  instruction word: opcode[15:12], rd[11:8], rs[7:4], rt[3:0].
- id_stall  out  1  combinational; upstream must hold IF/ID and the PC while this is high.
- SrcReg1  out  4  register file read address, port 1.
- SrcReg2  out  4  register file read address, port 2.
- SrcData1  in  16  register file read data, port 1 (combinational).
- SrcData2  in  16  register file read data, port 2 (combinational).
- wb_wen  in  1  writeback write enable. This is the same signal the register file sees as WriteReg.
- wb_reg  in  4  writeback destination register.
- wb_data  in  16  writeback data.
- flush  in  1  branch taken in EX; squash the instruction in ID.
- ex_valid, ex_opcode[3:0], ex_dst[3:0], ex_wen, ex_src1[3:0], ex_src2[3:0], ex_op1[16], ex_op2[16], ex_imm8[7:0]  out  ID/EX register contents.

## Operation
- Source selection from opcode:
  - src1 = rs for opcodes 0x0–0x9; rd for 0xA/0xB (LLB/LHB); none otherwise.
  - src2 = rt for 0x0–0x7; rd for 0x9 (SW); none otherwise.
- When a source is "none", its SrcReg output is 4'h0 and the source is treated as unused.
- Write decision: wen = 1 for opcodes 0x0–0x8, 0xA, 0xB and 0xE; dst = rd. wen is forced to 0 when rd = 0, because register 0 is hardwired to zero.
- Operand bypass, per port:
  - If wb_wen, wb_reg ≠ 0 and wb_reg == SrcRegN, the operand is wb_data.
  - Otherwise the operand is SrcDataN.
  - The register file only commits at the edge, so this bypass is mandatory.
  - Register 0 always reads 16'h0000, regardless of the bypass.
- Load-use hazard, raised as id_stall = 1 when all of the following hold:
  - id_valid and ex_valid are both set;
  - ex_opcode == 4'h8 (LW) and ex_wen;
  - ex_dst equals a used, nonzero source of the ID instruction.
- ID/EX update, in priority order, each rising edge:
  1. rst: every ex_* output is cleared to 0.
  2. flush: ex_valid ← 0, and all other ex_* fields are cleared to 0. Flush overrides stall; id_stall is masked to 0 while flush is high.
  3. id_stall: a bubble is inserted (ex_valid ← 0, ex_wen ← 0). IF/ID holds, so the instruction is re-evaluated the next cycle with fresh bypass.
  4. Otherwise all fields load from ID: ex_valid ← id_valid, ex_wen ← wen & id_valid, ex_imm8 ← id_instr[7:0].
- An invalid ID slot (id_valid = 0) never stalls and always loads a bubble.

## Timing
- Latency: operands are sampled in the cycle the instruction sits in ID and appear on ex_* one edge later.
- SrcReg1/2 and id_stall are purely combinational from id_instr, id_valid and the ID/EX state.
- A load-use stall lasts exactly one cycle. On the next cycle the LW has left ID/EX, so the condition clears. The loaded value then arrives through the register file or the bypass path.
- Reset mid-operation: any pending stall is dropped and ID/EX becomes empty on the reset edge. id_stall is 0 while ex_valid = 0.
- Simultaneous writeback and read of the same register: the bypass data wins. Two ports reading the same register bypass independently.

## Test plan
- Reset: assert rst for 2 cycles with id_valid = 1 → all ex_* = 0 and id_stall = 0 after the first edge.
- ADD R3,R1,R2 with R1 = 0x0005 and R2 = 0x0007 in the file → SrcReg1 = 1, SrcReg2 = 2; next edge ex_op1 = 0x0005, ex_op2 = 0x0007, ex_dst = 3, ex_wen = 1.
- Bypass: same ADD while wb_wen = 1, wb_reg = 2, wb_data = 0xBEEF → ex_op2 = 0xBEEF, ex_op1 = 0x0005. Repeat with wb_reg = 0 → ex_op2 = 0x0007 (no bypass).
- Load-use: LW R4 in ID/EX, then SUB R5,R4,R1 in ID → id_stall = 1 for one cycle and a bubble enters (ex_valid = 0). The next edge loads SUB with ex_op1 = the bypassed load data.
- Flush vs stall: same hazard with flush = 1 → id_stall = 0 and ex_valid = 0 on the edge.
- Register 0: ADD R0,R0,R0 with wb_wen = 1, wb_reg = 0, wb_data = 0x1234 → ex_op1 = ex_op2 = 0x0000 and ex_wen = 0. SW R2,[R1] → SrcReg2 = rd = 2 and ex_wen = 0.
